// File: rtl/apb_sin_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// apb_sin_pkg
// Shared types and constants for the sine-sweep APB requester:
//   sweep_state_t  - top-level sweep sequencer states
//   xfer_state_t   - single-transfer engine states
//   CTRL_ADDR_DEF  - default address of the slave control register (holds n)
//   OUT_ADDR_DEF   - default address of the slave output register (sample)
//   apb_word_t     - 32-bit APB data word
// -----------------------------------------------------------------------------
package apb_sin_pkg;

    localparam int unsigned CTRL_ADDR_DEF = 0;
    localparam int unsigned OUT_ADDR_DEF  = 4;

    typedef logic [31:0] apb_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_ACCESS,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_EMIT
    } sweep_state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_state_t;

endpackage

// File: rtl/apb_sin_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// apb_sin_sweep_ctrl_if
// APB bus bundle between the sweep requester (master) and the sine slave.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : requester -> slave
//   PRDATA, PREADY                       : slave -> requester
// -----------------------------------------------------------------------------
interface apb_sin_sweep_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );

endinterface

// File: rtl/apb_sin_sweep_ctrl_xfer.sv
// -----------------------------------------------------------------------------
// apb_sin_xfer
// Single-transfer APB engine: one SETUP cycle, then ACCESS until PREADY.
// All APB outputs are registered. A new req may be raised in the same cycle
// that ack is returned, which moves straight into the next SETUP.
//   PCLK, PRESET   : clock, asynchronous active-low reset
//   req/wr/addr/wdata : start a transfer (wdata only used when wr=1)
//   ack            : ACCESS completing this cycle (PREADY seen)
//   rdata          : PRDATA, valid when ack is high on a read
//   tout           : ACCESS abandoned after TIMEOUT_CYC PREADY-low cycles
//   apb            : APB master modport
// Optional macro APB_SIN_SWEEP_TIMEOUT_EN builds the wait-state timeout;
// without it ACCESS waits indefinitely and tout is constant 0.
// -----------------------------------------------------------------------------
module apb_sin_xfer
    import apb_sin_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  tout,
    apb_sin_sweep_ctrl_if.master  apb
);

    xfer_state_t       xst_q, xst_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    assign ack   = (xst_q == X_ACCESS) && apb.PREADY;
    assign rdata = apb.PRDATA;

`ifdef APB_SIN_SWEEP_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts consecutive PREADY-low ACCESS cycles; fires on the last allowed one.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        tout       = 1'b0;
        if (req) begin
            wait_cnt_d = '0;
        end else if ((xst_q == X_ACCESS) && !apb.PREADY) begin
            if (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
                tout       = 1'b1;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYC;
    assign tout = 1'b0;
`endif

    always_comb begin
        xst_d     = xst_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        case (xst_q)
            X_SETUP: begin
                xst_d     = X_ACCESS;
                penable_d = 1'b1;
            end
            X_ACCESS: begin
                if (ack || tout) begin
                    xst_d     = X_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: ;
        endcase
        // A request overrides the return to idle so back-to-back transfers
        // still pass through a SETUP cycle. PWDATA keeps its value on reads.
        if (req) begin
            xst_d     = X_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = wr;
            paddr_d   = addr;
            if (wr) begin
                pwdata_d = wdata;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            xst_q     <= X_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            xst_q     <= xst_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = pwdata_q;

endmodule

// File: rtl/apb_sin_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// apb_sin_sweep_ctrl
// Sweeps the sine-lookup APB slave over n = n_start + k*n_step, k = 0..count-1.
// Each sample: write n to CTRL_ADDR, read OUT_ADDR, offer the result on a
// valid/ready stream. Five cycles per sample with no wait states/backpressure.
//   PCLK, PRESET            : clock, asynchronous active-low reset
//   start, n_start, n_step, count : sweep request, sampled only in IDLE
//   busy, done, error       : status (done is a 1-cycle pulse, error sticky)
//   smp_valid/ready, smp_n, smp_data : sample stream
//   apb                     : APB master modport to the sine slave
// Optional macro APB_SIN_SWEEP_TIMEOUT_EN enables the ACCESS wait-state
// timeout (TIMEOUT_CYC cycles); without it error is constant 0.
// -----------------------------------------------------------------------------
module apb_sin_sweep_ctrl
    import apb_sin_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CNT_W       = 16,
    parameter logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(CTRL_ADDR_DEF),
    parameter logic [ADDR_W-1:0] OUT_ADDR    = ADDR_W'(OUT_ADDR_DEF),
    parameter int unsigned       TIMEOUT_CYC = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  start,
    input  logic [DATA_W-1:0]     n_start,
    input  logic [DATA_W-1:0]     n_step,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  smp_valid,
    input  logic                  smp_ready,
    output logic [DATA_W-1:0]     smp_n,
    output logic [DATA_W-1:0]     smp_data,
    apb_sin_sweep_ctrl_if.master  apb
);

    sweep_state_t      state_q, state_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] smp_n_q, smp_n_d;
    logic [DATA_W-1:0] smp_data_q, smp_data_d;
    logic              done_q, done_d;

    logic              req, req_wr, ack, tout, accept;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] rdata;

    assign accept = (state_q == S_IDLE) && start && (count != '0);

    apb_sin_xfer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_xfer (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .req   (req),
        .wr    (req_wr),
        .addr  (req_addr),
        .wdata (n_d),
        .ack   (ack),
        .rdata (rdata),
        .tout  (tout),
        .apb   (apb)
    );

    // Requests are raised on the transition into a SETUP state so the engine's
    // SETUP cycle coincides with WR_SETUP/RD_SETUP here. Write data is n_d:
    // the index this write is about to announce.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        step_d     = step_q;
        rem_d      = rem_q;
        smp_n_d    = smp_n_q;
        smp_data_d = smp_data_q;
        done_d     = 1'b0;
        req        = 1'b0;
        req_wr     = 1'b0;
        req_addr   = CTRL_ADDR;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    n_d     = n_start;
                    step_d  = n_step;
                    rem_d   = count;
                    state_d = S_WR_SETUP;
                    req     = 1'b1;
                    req_wr  = 1'b1;
                end else if (start) begin
                    done_d = 1'b1;
                end
            end
            S_WR_SETUP: state_d = S_WR_ACCESS;
            S_WR_ACCESS: begin
                if (tout) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (ack) begin
                    state_d  = S_RD_SETUP;
                    req      = 1'b1;
                    req_addr = OUT_ADDR;
                end
            end
            S_RD_SETUP: state_d = S_RD_ACCESS;
            S_RD_ACCESS: begin
                if (tout) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (ack) begin
                    smp_data_d = rdata;
                    smp_n_d    = n_q;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (smp_ready) begin
                    n_d   = n_q + step_q;
                    rem_d = rem_q - 1'b1;
                    // rem_q == 1 means this handshake consumed the last sample.
                    if (rem_q != CNT_W'(1)) begin
                        state_d = S_WR_SETUP;
                        req     = 1'b1;
                        req_wr  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            step_q     <= '0;
            rem_q      <= '0;
            smp_n_q    <= '0;
            smp_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            step_q     <= step_d;
            rem_q      <= rem_d;
            smp_n_q    <= smp_n_d;
            smp_data_q <= smp_data_d;
            done_q     <= done_d;
        end
    end

`ifdef APB_SIN_SWEEP_TIMEOUT_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end else if (tout) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign smp_valid = (state_q == S_EMIT);
    assign smp_n     = smp_n_q;
    assign smp_data  = smp_data_q;

endmodule

// File: tb/tb_apb_sin_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_sin_sweep_ctrl
// Drives sweeps into apb_sin_sweep_ctrl against a behavioural sine slave that
// returns 32'hA000_0000 + (last n written). Expected writes and samples are
// queued when a sweep is issued; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_apb_sin_sweep_ctrl;
    import apb_sin_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        start = 1'b0;
    logic [31:0] n_start = '0;
    logic [31:0] n_step = '0;
    logic [15:0] count = '0;
    logic        smp_ready = 1'b0;
    logic        busy, done, error, smp_valid;
    logic [31:0] smp_n, smp_data;

    always #5 PCLK = ~PCLK;

    apb_sin_sweep_ctrl_if #(.ADDR_W(32), .DATA_W(32)) apb ();

    apb_sin_sweep_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16),
        .CTRL_ADDR(32'd0), .OUT_ADDR(32'd4), .TIMEOUT_CYC(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .start(start), .n_start(n_start),
        .n_step(n_step), .count(count), .busy(busy), .done(done),
        .error(error), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_n(smp_n), .smp_data(smp_data), .apb(apb)
    );

    // Behavioural slave: control register holds n, output register = A000_0000 + n.
    logic [31:0] slave_reg = '0;
    assign apb.PRDATA = 32'hA000_0000 + slave_reg;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Scoreboard queues and monitor state
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_n_q[$];
    logic [31:0] exp_d_q[$];
    int  ws = 0, bp = 0;
    bit  stall = 1'b0;
    bit  zero_lat = 1'b0;
    int  cyc = 0, start_cyc = 0, last_hs = 0, done_cyc = 0;
    int  done_cnt = 0, hs_in_sweep = 0, psel_cnt = 0, acc_total = 0;

    // Slave PREADY and consumer smp_ready, updated just after each rising edge.
    initial begin
        int acc = 0;
        int emit = 0;
        apb.PREADY = 1'b1;
        forever begin
            @(posedge PCLK);
            #1;
            if (apb.PSEL && apb.PENABLE) begin
                apb.PREADY = !stall && (acc >= ws);
                acc++;
            end else begin
                acc = 0;
                apb.PREADY = 1'($urandom_range(0, 1));
            end
            if (smp_valid) begin
                smp_ready = (emit >= bp);
                emit++;
            end else begin
                emit = 0;
                smp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor
    logic [31:0] cap_addr, cap_wd, cap_sn, cap_sd;
    logic        cap_wr;
    bit          prev_valid = 1'b0, prev_setup = 1'b0, prev_access = 1'b0;

    always @(negedge PCLK) begin
        cyc++;
        if (!PRESET) begin
            prev_valid  = 1'b0;
            prev_setup  = 1'b0;
            prev_access = 1'b0;
        end else begin
            if (start && !busy) start_cyc = cyc;
            if (apb.PSEL) psel_cnt++;
            if (apb.PSEL && !apb.PENABLE) begin
                cap_addr = apb.PADDR;
                cap_wd   = apb.PWDATA;
                cap_wr   = apb.PWRITE;
            end
            if (apb.PSEL && apb.PENABLE) begin
                acc_total++;
                if (!prev_access) chk("setup_before_access", 32'(prev_setup), 32'd1);
                chk("access_hold", {29'd0, apb.PADDR == cap_addr, apb.PWDATA == cap_wd,
                                    apb.PWRITE == cap_wr}, 32'd7);
                if (apb.PREADY) begin
                    if (apb.PWRITE) begin
                        chk("wr_addr", apb.PADDR, 32'd0);
                        if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                        else chk("wr_n", apb.PWDATA, exp_wr_q.pop_front());
                        slave_reg = apb.PWDATA;
                    end else begin
                        chk("rd_addr", apb.PADDR, 32'd4);
                    end
                end
            end
            prev_setup  = apb.PSEL && !apb.PENABLE;
            prev_access = apb.PSEL && apb.PENABLE && !apb.PREADY;
            if (smp_valid) begin
                if (!prev_valid) begin
                    cap_sn = smp_n;
                    cap_sd = smp_data;
                end else begin
                    chk("smp_hold", {30'd0, smp_n == cap_sn, smp_data == cap_sd}, 32'd3);
                end
                if (smp_ready) begin
                    if (exp_n_q.size() == 0) begin
                        chk("smp_unexpected", 32'd1, 32'd0);
                    end else begin
                        chk("smp_n", smp_n, exp_n_q.pop_front());
                        chk("smp_data", smp_data, exp_d_q.pop_front());
                    end
                    if (zero_lat) begin
                        if (hs_in_sweep == 0) chk("first_latency", 32'(cyc - start_cyc), 32'd5);
                        else chk("sample_spacing", 32'(cyc - last_hs), 32'd5);
                    end
                    hs_in_sweep++;
                    last_hs = cyc;
                end
            end
            prev_valid = smp_valid && !smp_ready;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic issue_start(input logic [31:0] ns, input logic [31:0] st, input int cnt);
        @(posedge PCLK);
        #1;
        n_start = ns;
        n_step  = st;
        count   = 16'(cnt);
        start   = 1'b1;
        @(posedge PCLK);
        #1;
        start   = 1'b0;
        n_start = $urandom;
        n_step  = $urandom;
        count   = 16'($urandom);
    endtask

    task automatic push_expect(input logic [31:0] ns, input logic [31:0] st, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] v;
            v = ns + 32'(i) * st;
            exp_wr_q.push_back(v);
            exp_n_q.push_back(v);
            exp_d_q.push_back(32'hA000_0000 + v);
        end
    endtask

    task automatic run_sweep(input logic [31:0] ns, input logic [31:0] st, input int cnt,
                             input int w, input int b, input bit busy_start);
        ws = w;
        bp = b;
        zero_lat = (w == 0) && (b == 0);
        push_expect(ns, st, cnt);
        done_cnt = 0;
        hs_in_sweep = 0;
        psel_cnt = 0;
        issue_start(ns, st, cnt);
        if (busy_start) begin
            repeat (5) @(posedge PCLK);
            #1;
            chk("busy_mid_sweep", 32'(busy), 32'd1);
            start   = 1'b1;
            count   = 16'd3;
            n_start = 32'h1234_5678;
            @(posedge PCLK);
            #1;
            start   = 1'b0;
        end
        for (int t = 0; t < 5000 && done_cnt == 0; t++) @(posedge PCLK);
        repeat (3) @(posedge PCLK);
        #1;
        chk("done_count", 32'(done_cnt), 32'd1);
        if (cnt == 0) begin
            chk("done_latency_cnt0", 32'(done_cyc - start_cyc), 32'd1);
            chk("no_psel_cnt0", 32'(psel_cnt), 32'd0);
        end else begin
            chk("done_after_last_hs", 32'(done_cyc - last_hs), 32'd1);
        end
        chk("sample_count", 32'(hs_in_sweep), 32'(cnt));
        chk("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("valid_after_done", 32'(smp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_valid", 32'(smp_valid), 32'd0);
        chk("rst_smp_n", smp_n, 32'd0);
        chk("rst_smp_data", smp_data, 32'd0);
        chk("rst_apb", {29'd0, apb.PSEL, apb.PENABLE, apb.PWRITE}, 32'd0);
        chk("rst_paddr", apb.PADDR, 32'd0);
        chk("rst_pwdata", apb.PWDATA, 32'd0);
        PRESET = 1'b1;

        // Basic sweep, wrap-around, wait states with backpressure
        run_sweep(32'd0, 32'd1, 10, 0, 0, 1'b0);
        run_sweep(32'hFFFF_FFFE, 32'd1, 4, 0, 0, 1'b0);
        run_sweep($urandom, $urandom, 5, 3, 2, 1'b0);

        // Start edge cases: count=0, then a start while busy
        run_sweep($urandom, $urandom, 0, 0, 0, 1'b0);
        run_sweep($urandom, $urandom, 4, 1, 0, 1'b1);

        // Randomized sweeps
        for (int k = 0; k < 8; k++) begin
            run_sweep($urandom, $urandom, int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset during RD_ACCESS of sample 3
        ws = 3;
        bp = 1;
        zero_lat = 1'b0;
        push_expect(32'h0000_0100, 32'd7, 6);
        done_cnt = 0;
        hs_in_sweep = 0;
        issue_start(32'h0000_0100, 32'd7, 6);
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge PCLK);
            #1;
            found = (hs_in_sweep == 2) && apb.PSEL && apb.PENABLE && !apb.PWRITE;
        end
        chk("reached_rd_access_3", 32'(found), 32'd1);
        #1;
        PRESET = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid_done", {30'd0, smp_valid, done}, 32'd0);
        chk("arst_apb", {29'd0, apb.PSEL, apb.PENABLE, apb.PWRITE}, 32'd0);
        chk("arst_paddr", apb.PADDR, 32'd0);
        chk("arst_pwdata", apb.PWDATA, 32'd0);
        chk("arst_smp", smp_n | smp_data, 32'd0);
        exp_wr_q.delete();
        exp_n_q.delete();
        exp_d_q.delete();
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        chk("no_done_after_reset", 32'(done_cnt), 32'd0);
        run_sweep(32'h0000_0100, 32'd7, 6, 0, 0, 1'b0);

`ifdef APB_SIN_SWEEP_TIMEOUT_EN
        // Timeout: PREADY held low in ACCESS
        stall = 1'b1;
        done_cnt = 0;
        hs_in_sweep = 0;
        acc_total = 0;
        issue_start(32'd5, 32'd1, 3);
        for (int t = 0; t < 200 && done_cnt == 0; t++) @(posedge PCLK);
        #1;
        chk("tout_done", 32'(done_cnt), 32'd1);
        chk("tout_access_cycles", 32'(acc_total), 32'd16);
        chk("tout_error", 32'(error), 32'd1);
        chk("tout_psel", 32'(apb.PSEL), 32'd0);
        chk("tout_no_sample", 32'(hs_in_sweep), 32'd0);
        stall = 1'b0;
        exp_wr_q.delete();
        slave_reg = '0;
        run_sweep(32'd9, 32'd3, 2, 0, 0, 1'b0);
`endif
        chk("error_clear", 32'(error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_sin_sweep_ctrl.md
Name: apb_sin_sweep_ctrl

Overview:
APB requester/sequencer that drives the sine-lookup APB slave through a programmed sweep of sample indices. For each index it writes n to the slave's control register, reads the result back from the output register, and presents the sample on a valid/ready stream. It replaces hand-sequenced bench stimulus, giving the system a single owner of the sine peripheral's bus.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width, and width of n and of samples
CNT_W, 16, width of the sample-count input
CTRL_ADDR, 0, address of the slave control register (holds n)
OUT_ADDR, 4, address of the slave output register (sample)
TIMEOUT_CYC, 16, maximum number of PREADY-low ACCESS cycles; used only with the optional feature

Ports:
PCLK  in  1  clock; all state updates on rising edge
PRESET  in  1  reset, asynchronous, active-low
start  in  1  begin a sweep; sampled only in IDLE
n_start  in  DATA_W  first index
n_step  in  DATA_W  index increment
count  in  CNT_W  number of samples to produce
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a sweep ends
error  out  1  sticky timeout flag
smp_valid  out  1  sample available
smp_ready  in  1  consumer accepts the sample
smp_n  out  DATA_W  index of the current sample
smp_data  out  DATA_W  PRDATA captured from OUT_ADDR
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction (1 = write)
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (PRESET=0, asynchronous): state goes to IDLE. All outputs are 0, and the internal n and remaining-count registers are 0. Asserting reset mid-sweep aborts immediately; no done pulse is generated.
- States: IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, EMIT.
- IDLE:
  - If start=1 and count≠0: latch n_start, n_step and count, clear error, go to WR_SETUP.
  - If start=1 and count=0: pulse done on the next cycle with no bus activity.
  - start is ignored outside IDLE.
- WR_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=CTRL_ADDR, PWDATA=n. Lasts one cycle, then WR_ACCESS.
- WR_ACCESS: PSEL=1 and PENABLE=1; PADDR, PWRITE and PWDATA are held stable. Stay while PREADY=0. When PREADY=1, go to RD_SETUP.
- RD_SETUP: PSEL=1, PENABLE=0, PWRITE=0, PADDR=OUT_ADDR, PWDATA holds its last value. Lasts one cycle, then RD_ACCESS.
- RD_ACCESS: PSEL=1 and PENABLE=1. When PREADY=1, capture smp_data=PRDATA and smp_n=n, then go to EMIT.
- PSEL and PENABLE are 0 in IDLE and EMIT. A transfer is never issued back-to-back without passing through SETUP.
- EMIT:
  - smp_valid=1. smp_data and smp_n are held stable until smp_ready=1.
  - On handshake: n ← n + n_step modulo 2^DATA_W (wrap, no saturation); remaining ← remaining − 1.
  - If the new remaining≠0, go to WR_SETUP. Otherwise go to IDLE with done=1 in that first IDLE cycle.
  - smp_ready while smp_valid=0 is ignored.
- Latency: with PREADY=1 and smp_ready=1, a sample takes exactly 5 cycles. smp_valid rises 4 cycles after leaving IDLE.
- n_start, n_step and count may change freely during a sweep; only the latched copies are used.

Optional Feature:
Macro: APB_SIN_SWEEP_TIMEOUT_EN.
- Enabled:
  - An ACCESS-state counter counts consecutive PREADY=0 cycles and resets on entering any SETUP state.
  - If it reaches TIMEOUT_CYC, the controller drops PSEL and PENABLE, sets error=1, goes to IDLE and pulses done there. No sample is emitted.
  - error stays set until the next accepted start.
- Disabled: ACCESS waits indefinitely. The error output is tied to 0 and the timeout counter is not built.

Decomposition:
- Package apb_sin_pkg holds:
  - the state enum sweep_state_t;
  - the constants CTRL_ADDR_DEF=0 and OUT_ADDR_DEF=4, used as parameter defaults;
  - typedef apb_word_t (logic [31:0]).
- One natural sub-module, apb_sin_xfer: a single-transfer SETUP→ACCESS engine. It takes req, wr, addr and wdata; it returns ack and rdata; it contains the timeout logic. The top FSM issues two transfers per sample through it.

Test Plan:
1. Basic sweep. Behavioural slave with PREADY=1 returns 32'hA000_0000 + (last written n). Stimulus: start with n_start=0, n_step=1, count=10, smp_ready=1. Required: writes of n=0..9 to address 0, each followed by a read of address 4; samples A000_0000..A000_0009 in order, 5 cycles apart; done pulses once, 1 cycle after the 10th handshake.
2. Wrap-around. Stimulus: n_start=32'hFFFF_FFFE, n_step=1, count=4. Required: written n = FFFF_FFFE, FFFF_FFFF, 0, 1.
3. Wait states and backpressure. Stimulus: PREADY low for 3 cycles in every ACCESS, smp_ready low for 2 cycles in EMIT. Required: PADDR, PWDATA and PWRITE stable throughout each ACCESS; smp_data and smp_n stable while smp_valid=1; sample order unchanged.
4. Start edge cases. Stimulus: start with count=0, then start again while busy. Required: done pulses 1 cycle after the count=0 start with PSEL never asserted; the start pulse issued while busy has no effect.
5. Reset mid-sweep. Stimulus: assert PRESET=0 during RD_ACCESS of sample 3. Required: outputs become 0 asynchronously, no done pulse; a subsequent start restarts from n_start.
6. Timeout (built with APB_SIN_SWEEP_TIMEOUT_EN, TIMEOUT_CYC=16). Stimulus: PREADY held at 0. Required: after 16 ACCESS cycles PSEL drops and error=1, done pulses, no smp_valid; error clears on the next start.
